// File: rtl/pi1_pkg.sv
// Shared PI1 definitions: op encodings, responder FSM states and address-width helpers.
package pi1_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } pi1r_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Word address width: byte-offset bits are dropped from the architectural address.
  function automatic int addrbitsz(input int archbitsz);
    return archbitsz - clog2(archbitsz / 8);
  endfunction

endpackage

// File: rtl/pi1r_ram_bank.sv
// Single-port word RAM with byte-enable writes and a registered read-before-write output.
module pi1r_ram_bank
  import pi1_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [clog2(DEPTH)-1:0]  idx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      sel,
  output logic [DATA_W-1:0]        rdata
);

  localparam int SEL_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Old word is captured in the same edge that may overwrite it, giving swap semantics.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (sel[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pi1r_ram.sv
// PI1 responder RAM with byte selects, RW swap and LATENCY wait states.
// Optional write protect input wrprot_i is added when PI1R_RAM_WRPROT_EN is defined.
module pi1r_ram
  import pi1_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int SIZE      = 1024,
  parameter int LATENCY   = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [1:0]                        pi1_op_i,
  input  logic [addrbitsz(ARCHBITSZ)-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]              pi1_data_i,
  output logic [ARCHBITSZ-1:0]              pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]            pi1_sel_i,
`ifdef PI1R_RAM_WRPROT_EN
  input  logic                              wrprot_i,
`endif
  output logic                              pi1_rdy_o,
  output logic [addrbitsz(ARCHBITSZ)-1:0]   pi1_mapsz_o
);

  localparam int ADDRBITSZ = addrbitsz(ARCHBITSZ);
  localparam int IDX_W     = clog2(SIZE);
  localparam int CNT_W     = (LATENCY > 1) ? clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  pi1r_state_e      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             accept;
  logic             wr_allow;
  logic             we, re;
  logic             unused_addr_bits;

  // Upper address bits alias onto the low index; they are deliberately ignored.
  assign unused_addr_bits = ^pi1_addr_i;

`ifdef PI1R_RAM_WRPROT_EN
  assign wr_allow = ~wrprot_i;
`else
  assign wr_allow = 1'b1;
`endif

  assign pi1_rdy_o   = (state_q == ST_IDLE) & ~rst_i;
  assign accept      = pi1_rdy_o & (pi1_op_i != PINOOP);
  assign we          = accept & pi1_op_i[0] & wr_allow;
  assign re          = accept & pi1_op_i[1];
  assign pi1_mapsz_o = ADDRBITSZ'(SIZE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (LATENCY != 0)) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_CNT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  pi1r_ram_bank #(
    .DATA_W (ARCHBITSZ),
    .DEPTH  (SIZE)
  ) u_bank (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (we),
    .re    (re),
    .idx   (pi1_addr_i[IDX_W-1:0]),
    .wdata (pi1_data_i),
    .sel   (pi1_sel_i),
    .rdata (pi1_data_o)
  );

endmodule

// File: tb/tb_pi1r_ram.sv
// Directed bench for pi1r_ram: one instance with LATENCY=0, one with LATENCY=3.
module tb_pi1r_ram;
  import pi1_pkg::*;

  localparam int AW = 30;

  logic          clk;
  logic          rst0, rst3;
  logic [1:0]    op0, op3;
  logic [AW-1:0] addr0, addr3;
  logic [31:0]   din0, din3;
  logic [31:0]   dout0, dout3;
  logic [3:0]    sel0, sel3;
  logic          rdy0, rdy3;
  logic [AW-1:0] mapsz0, mapsz3;
`ifdef PI1R_RAM_WRPROT_EN
  logic          wrprot0, wrprot3;
`endif

  int checks;
  int failures;

  pi1r_ram #(.ARCHBITSZ(32), .SIZE(1024), .LATENCY(0)) dut0 (
    .clk_i       (clk),
    .rst_i       (rst0),
    .pi1_op_i    (op0),
    .pi1_addr_i  (addr0),
    .pi1_data_i  (din0),
    .pi1_data_o  (dout0),
    .pi1_sel_i   (sel0),
`ifdef PI1R_RAM_WRPROT_EN
    .wrprot_i    (wrprot0),
`endif
    .pi1_rdy_o   (rdy0),
    .pi1_mapsz_o (mapsz0)
  );

  pi1r_ram #(.ARCHBITSZ(32), .SIZE(1024), .LATENCY(3)) dut3 (
    .clk_i       (clk),
    .rst_i       (rst3),
    .pi1_op_i    (op3),
    .pi1_addr_i  (addr3),
    .pi1_data_i  (din3),
    .pi1_data_o  (dout3),
    .pi1_sel_i   (sel3),
`ifdef PI1R_RAM_WRPROT_EN
    .wrprot_i    (wrprot3),
`endif
    .pi1_rdy_o   (rdy3),
    .pi1_mapsz_o (mapsz3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    op0 = op; addr0 = a; din0 = d; sel0 = s;
  endtask

  task automatic drive3(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    op3 = op; addr3 = a; din3 = d; sel3 = s;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1;
    drive0(PINOOP, '0, '0, '0);
    drive3(PINOOP, '0, '0, '0);
    cycle(); cycle();
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_rdy0 got=%b exp=0", rdy0); end
    checks++; if (dout0 !== 32'h0) begin failures++; $display("FAIL reset_data0 got=%h exp=0", dout0); end
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL reset_rdy3 got=%b exp=0", rdy3); end
    checks++; if (mapsz0 !== 30'd1024) begin failures++; $display("FAIL mapsz_in_reset got=%0d exp=1024", mapsz0); end
    rst0 = 1'b0; rst3 = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL rdy0_after_reset got=%b exp=1", rdy0); end
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL rdy3_after_reset got=%b exp=1", rdy3); end
  endtask

  task automatic test_write_read();
    drive0(PIWROP, 30'd5, 32'hDEADBEEF, 4'hF);
    cycle();
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL wr_rdy got=%b exp=1", rdy0); end
    drive0(PIRDOP, 30'd5, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", dout0); end
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL rd_rdy got=%b exp=1", rdy0); end
  endtask

  task automatic test_byte_select();
    drive0(PIWROP, 30'd5, 32'h11223344, 4'b0101);
    cycle();
    drive0(PIRDOP, 30'd5, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'hDE22BE44) begin failures++; $display("FAIL byte_sel got=%h exp=de22be44", dout0); end
  endtask

  task automatic test_swap();
    drive0(PIWROP, 30'd7, 32'h12345678, 4'hF);
    cycle();
    drive0(PIRWOP, 30'd7, 32'hA5A5A5A5, 4'hF);
    cycle();
    checks++; if (dout0 !== 32'h12345678) begin failures++; $display("FAIL swap_old got=%h exp=12345678", dout0); end
    drive0(PIRDOP, 30'd7, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'hA5A5A5A5) begin failures++; $display("FAIL swap_new got=%h exp=a5a5a5a5", dout0); end
    drive0(PIRWOP, 30'd7, 32'h00000000, 4'b0011);
    cycle();
    checks++; if (dout0 !== 32'hA5A5A5A5) begin failures++; $display("FAIL swap_masked_old got=%h exp=a5a5a5a5", dout0); end
    drive0(PIRDOP, 30'd7, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'hA5A50000) begin failures++; $display("FAIL swap_masked_new got=%h exp=a5a50000", dout0); end
  endtask

  task automatic test_noop_hold();
    drive0(PINOOP, 30'd5, 32'hFFFFFFFF, 4'hF);
    cycle(); cycle();
    checks++; if (dout0 !== 32'hA5A50000) begin failures++; $display("FAIL noop_hold got=%h exp=a5a50000", dout0); end
    drive0(PIRDOP, 30'd5, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'hDE22BE44) begin failures++; $display("FAIL noop_no_write got=%h exp=de22be44", dout0); end
  endtask

  task automatic test_alias();
    drive0(PIWROP, 30'h400, 32'h00000001, 4'hF);
    cycle();
    drive0(PIRDOP, 30'h000, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'h00000001) begin failures++; $display("FAIL alias got=%h exp=00000001", dout0); end
    drive0(PINOOP, '0, '0, '0);
  endtask

  task automatic test_latency();
    logic [4:0] exp_pat;
    logic [4:0] got_pat;
    exp_pat = 5'b10001;
    drive3(PIWROP, 30'd9, 32'h0BADF00D, 4'hF);
    for (int i = 4; i >= 0; i--) begin
      got_pat[i] = rdy3;
      if (i != 0) cycle();
    end
    checks++; if (got_pat !== exp_pat) begin failures++; $display("FAIL lat_rdy_pattern got=%b exp=%b", got_pat, exp_pat); end
    drive3(PIRDOP, 30'd9, 32'h0, 4'h0);
    cycle();
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL lat_rd_wait got=%b exp=0", rdy3); end
    cycle(); cycle(); cycle();
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL lat_rd_rdy got=%b exp=1", rdy3); end
    checks++; if (dout3 !== 32'h0BADF00D) begin failures++; $display("FAIL lat_rd_data got=%h exp=0badf00d", dout3); end
    drive3(PINOOP, '0, '0, '0);
  endtask

  task automatic test_reset_mid_wait();
    drive3(PIWROP, 30'h400, 32'h00000001, 4'hF);
    cycle();
    drive3(PINOOP, '0, '0, '0);
    cycle();
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL midwait_pre got=%b exp=0", rdy3); end
    rst3 = 1'b1;
    drive3(PIWROP, 30'h000, 32'hFFFFFFFF, 4'hF);
    cycle();
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL midwait_rst_rdy got=%b exp=0", rdy3); end
    checks++; if (dout3 !== 32'h0) begin failures++; $display("FAIL midwait_rst_data got=%h exp=0", dout3); end
    checks++; if (mapsz3 !== 30'd1024) begin failures++; $display("FAIL midwait_mapsz got=%0d exp=1024", mapsz3); end
    cycle();
    drive3(PINOOP, '0, '0, '0);
    rst3 = 1'b0;
    #1;
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL midwait_release_rdy got=%b exp=1", rdy3); end
    drive3(PIRDOP, 30'h000, 32'h0, 4'h0);
    cycle();
    drive3(PINOOP, '0, '0, '0);
    cycle(); cycle(); cycle();
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL midwait_rd_rdy got=%b exp=1", rdy3); end
    checks++; if (dout3 !== 32'h00000001) begin failures++; $display("FAIL midwait_ram_kept got=%h exp=00000001", dout3); end
  endtask

`ifdef PI1R_RAM_WRPROT_EN
  task automatic test_wrprot();
    drive0(PIWROP, 30'd3, 32'h0, 4'hF);
    cycle();
    wrprot0 = 1'b1;
    drive0(PIWROP, 30'd3, 32'h000000FF, 4'hF);
    cycle();
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL wrprot_rdy got=%b exp=1", rdy0); end
    drive0(PIRDOP, 30'd3, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'h0) begin failures++; $display("FAIL wrprot_wr got=%h exp=0", dout0); end
    drive0(PIRWOP, 30'd3, 32'h55555555, 4'hF);
    cycle();
    checks++; if (dout0 !== 32'h0) begin failures++; $display("FAIL wrprot_rw_old got=%h exp=0", dout0); end
    wrprot0 = 1'b0;
    drive0(PIRDOP, 30'd3, 32'h0, 4'h0);
    cycle();
    checks++; if (dout0 !== 32'h0) begin failures++; $display("FAIL wrprot_rw_mem got=%h exp=0", dout0); end
    drive0(PINOOP, '0, '0, '0);
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
`ifdef PI1R_RAM_WRPROT_EN
    wrprot0 = 1'b0;
    wrprot3 = 1'b0;
`endif
    #1;
    test_reset();
    test_write_read();
    test_byte_select();
    test_swap();
    test_noop_hold();
    test_alias();
    test_latency();
    test_reset_mid_wait();
`ifdef PI1R_RAM_WRPROT_EN
    test_wrprot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pi1r_ram.md
Name: pi1r_ram

Overview:
- PI1 responder (slave end of the pi1r interconnect): a word-addressed single-port RAM with byte selects, a read-modify-write swap, and programmable wait states.
- Sits on one slave port of the interconnect and advertises its mapped size through `pi1_mapsz_o`.
- Serves as the reference responder for bring-up and the model target for interconnect verification.

Parameters:
- ARCHBITSZ, 32, data width in bits; byte-select width is ARCHBITSZ/8.
- SIZE, 1024, depth in words; must be a power of two ≥ 2.
- LATENCY, 0, extra wait cycles per accepted op (0..15); sets the width of the wait counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- pi1_op_i  in  2  op: 00 NOOP, 01 WR, 10 RD, 11 RW.
- pi1_addr_i  in  ARCHBITSZ-clog2(ARCHBITSZ/8)  word address.
- pi1_data_i  in  ARCHBITSZ  write data.
- pi1_data_o  out  ARCHBITSZ  read data.
- pi1_sel_i  in  ARCHBITSZ/8  byte enables.
- pi1_rdy_o  out  1  ready / op-accept.
- pi1_mapsz_o  out  ADDRBITSZ  constant SIZE.

Interface (already decided):
- One clock, `clk_i`.
- Reset `rst_i` is synchronous and active-high.

Behaviour:
- Accept rule: an op is accepted in a cycle where pi1_rdy_o=1 and pi1_op_i≠NOOP. All inputs are sampled only in that cycle.
- Index: idx = pi1_addr_i[clog2(SIZE)-1:0]. Higher address bits are ignored, so addresses alias modulo SIZE.
- WR: each byte b with sel[b]=1 is written at the accept edge. Bytes with sel[b]=0 are unchanged.
- RD: the full word at idx is captured into the data register. pi1_data_o is valid in the first later cycle with pi1_rdy_o=1 and holds until the next RD/RW result. Byte selects do not mask read data.
- RW (swap): the old word goes to pi1_data_o under the RD rule. The sel-masked pi1_data_i is written in the same accept edge.
- Wait states, LATENCY=0: pi1_rdy_o stays 1 outside reset, and back-to-back ops are accepted every cycle. A RD at cycle T yields data at T+1, simultaneous with acceptance of the next op.
- Wait states, LATENCY=N>0: FSM states IDLE and WAIT.
  - IDLE: rdy=1. An accept loads cnt=N and moves to WAIT.
  - WAIT: rdy=0 and cnt decrements. When cnt=1 → IDLE.
  - Total accept-to-next-rdy spacing is N+1 cycles.
  - Memory side effects occur at the accept edge. The data register is loaded at the accept edge.
- NOOP in IDLE: no state change and no memory access. pi1_data_o holds.
- Reset, while rst_i=1:
  - pi1_rdy_o=0, FSM→IDLE, cnt=0, pi1_data_o=0.
  - Ops are ignored and RAM contents are preserved.
  - Reset asserted during WAIT aborts the wait. A write already accepted is not undone.
  - First accept is possible in the cycle after rst_i falls.
- pi1_mapsz_o = SIZE, constant, including during reset.

Optional Feature:
- Macro: PI1R_RAM_WRPROT_EN.
- When defined, an extra input `wrprot_i` (1 bit) is added. While wrprot_i=1 at the accept edge, the write half of WR/RW is suppressed. RW still returns the old data, and handshake timing is unchanged.
- When undefined, there is no port and all writes proceed.

Decomposition:
- Shared package pi1_pkg: op constants PINOOP/PIWROP/PIRDOP/PIRWOP, the clog2 function, and the ADDRBITSZ derivation.
- One sub-module, pi1r_ram_bank: single-port RAM with byte-enable write and registered read-before-write output. The wait FSM and handshake stay in pi1r_ram.

Test Plan:
- LATENCY=0: WR addr 5 data 0xDEADBEEF sel 0xF, then RD addr 5 → rdy stays 1; data_o=0xDEADBEEF in the cycle after the RD accept.
- Byte select: WR addr 5 data 0x11223344 sel 0b0101 over 0xDEADBEEF, then RD → 0xDE22BE44.
- Swap: RW addr 7 data 0xA5A5A5A5 over 0x12345678 → data_o=0x12345678; subsequent RD addr 7 → 0xA5A5A5A5.
- LATENCY=3: ops held continuously → rdy pattern 1,0,0,0,1; accepts spaced 4 cycles apart; RD data valid when rdy returns.
- Alias/reset: SIZE=1024, WR addr 0x400 data 1 → RD addr 0 returns 1. Assert rst_i mid-WAIT → rdy=0, data_o=0; after release rdy=1 and RAM still holds 1.
- PI1R_RAM_WRPROT_EN: wrprot_i=1, WR addr 3 data 0xFF over 0 → RD returns 0; RW returns old value and memory is unchanged.
